// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared definitions for the RTC reader: counter width, read FSM state
// encoding and the alarm crossing test applied on every snapshot update.
package rtc_pkg;

  localparam int RTC_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rd_state_e;

  // True when the counter passed or landed on the alarm value while moving
  // from snap_old to snap_new. A decreasing value is treated as a wrap
  // through zero. The very first snapshot after reset has no history, so
  // only an exact match counts.
  function automatic logic alarm_hit(input logic [RTC_W-1:0] snap_old,
                                     input logic [RTC_W-1:0] snap_new,
                                     input logic [RTC_W-1:0] alarm,
                                     input logic             first_snap);
    logic hit;
    if (first_snap)
      hit = (snap_new == alarm);
    else if (snap_new < snap_old)
      hit = (alarm > snap_old) || (alarm <= snap_new);
    else
      hit = ((snap_old < alarm) && (alarm <= snap_new)) || (snap_new == alarm);
    return hit;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// bus_sync
// Per-bit multi-flop synchronizer. Every bit is synchronized independently,
// so a multi-bit bus may arrive incoherent; coherence is the caller's job.
// Ports:
//   clk   - destination clock
//   rstb  - asynchronous active-low reset, clears all stages
//   d     - asynchronous input bus
//   q     - synchronized bus (STAGES clk of latency)
module bus_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rtc_reader.sv
// rtc_reader
// Reads a free-running asynchronous ripple counter coherently. The bus is
// synchronized bit by bit, then a stability filter accepts a value only
// after it has been seen unchanged for MATCH consecutive comparisons. Reads
// use a 4-phase rd_req/rd_ack handshake and fall back to the last good
// snapshot (with rd_err) if no stable value shows up within TIMEOUT clk.
// A sticky alarm interrupt fires when a snapshot update crosses the alarm.
//
// state | meaning
// IDLE  | no read in progress, rd_ack low
// WAIT  | read pending, waiting for a stable value or the timeout
// ACK   | rd_ack high with rd_data/rd_err valid, waiting for rd_req low
//
// Ports:
//   clk, rstb          - system clock, asynchronous active-low reset
//   rtc                - asynchronous 48-bit counter value
//   rd_req / rd_ack    - 4-phase read handshake
//   rd_data / rd_err   - read result, valid while rd_ack is high
//   alarm, alarm_en    - alarm compare value and enable
//   irq_clr, alarm_irq - clear pulse and sticky alarm interrupt
module rtc_reader
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MATCH       = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [RTC_W-1:0] rtc,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [RTC_W-1:0] rd_data,
  output logic             rd_err,
  input  logic [RTC_W-1:0] alarm,
  input  logic             alarm_en,
  input  logic             irq_clr,
  output logic             alarm_irq
);

  localparam int CNT_W  = $clog2(MATCH + 1);
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]  MATCH_C   = CNT_W'(MATCH);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(SYNC_STAGES + 1);

  logic [RTC_W-1:0]  rtc_s;
  logic [RTC_W-1:0]  rtc_p;
  logic [CNT_W-1:0]  stab_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic [RTC_W-1:0]  snap;
  logic              snap_vld;
  logic              stable;
  logic              hit;

  rd_state_e         state, state_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic              rd_ack_n;
  logic [RTC_W-1:0]  rd_data_n;
  logic              rd_err_n;

  bus_sync #(
    .WIDTH  (RTC_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (rtc),
    .q    (rtc_s)
  );

  // Right after reset rtc_s and rtc_p hold the reset value, not a sample of
  // the counter. fill_cnt holds off the filter until the pipeline carries
  // real samples, so a zero from reset is never taken as a stable reading.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rtc_p    <= '0;
      stab_cnt <= '0;
      fill_cnt <= FILL_INIT;
    end else begin
      rtc_p <= rtc_s;
      if (fill_cnt != '0) fill_cnt <= fill_cnt - 1'b1;
      if ((fill_cnt == '0) && (rtc_s == rtc_p)) begin
        if (stab_cnt != MATCH_C) stab_cnt <= stab_cnt + 1'b1;
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  // stab_cnt reflects comparisons up to the previous cycle, so in a
  // qualifying cycle rtc_p is the value that actually passed the filter,
  // while rtc_s may already be the first sample of a new ripple. Loading
  // rtc_p keeps transients out of snap and rd_data; when nothing is moving
  // the two are identical.
  assign stable = (stab_cnt == MATCH_C);
  assign hit    = alarm_en && stable && alarm_hit(snap, rtc_p, alarm, !snap_vld);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      snap      <= '0;
      snap_vld  <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      if (stable) begin
        snap     <= rtc_p;
        snap_vld <= 1'b1;
      end
      // A new hit outranks a clear arriving in the same cycle.
      if (hit)
        alarm_irq <= 1'b1;
      else if (irq_clr)
        alarm_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      to_cnt  <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      state   <= state_n;
      to_cnt  <= to_cnt_n;
      rd_ack  <= rd_ack_n;
      rd_data <= rd_data_n;
      rd_err  <= rd_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    to_cnt_n  = to_cnt;
    rd_ack_n  = rd_ack;
    rd_data_n = rd_data;
    rd_err_n  = rd_err;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          state_n  = WAIT;
          to_cnt_n = '0;
        end
      end
      WAIT: begin
        if (!rd_req) begin
          state_n = IDLE;
        end else if (stable) begin
          rd_data_n = rtc_p;
          rd_err_n  = 1'b0;
          rd_ack_n  = 1'b1;
          state_n   = ACK;
        end else if (to_cnt == TO_LAST) begin
          rd_data_n = snap;
          rd_err_n  = 1'b1;
          rd_ack_n  = 1'b1;
          state_n   = ACK;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      ACK: begin
        if (!rd_req) begin
          rd_ack_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        rd_ack_n = 1'b0;
      end
    endcase
  end

endmodule
